// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Purpose:
//   Multi-digit up/down counter driven by two debounced push buttons. The
//   counter works in hex or BCD digits and either wraps or saturates at the
//   end of its range. Holding a button auto-repeats after a programmable
//   delay, at a programmable rate. Display helper outputs flag leading zeros
//   for blanking and light the least significant decimal point while
//   auto-repeat is running.
//
// Parameters:
//   MODE          "HEX" (base 16 digits) or "DEC" (base 10 digits)
//   NUM_SEGMENTS  number of 4-bit digits, 1..8
//   LIMIT         "WRAP" or "SAT" behaviour at either end of the range
//   REPEAT_DELAY  hold cycles before auto-repeat starts, 0 = no auto-repeat
//   REPEAT_RATE   cycles between auto-repeat steps, >= 1
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   btn_up       debounced level, high while the increment button is held
//   btn_down     debounced level, high while the decrement button is held
//   encoded      count, one nibble per digit, digit 0 least significant
//   digit_point  active-low decimal points, bit 0 low while auto-repeating
//   digit_blank  1 = digit is a leading zero and may be blanked
//   overflow     one-cycle pulse when an increment passes the maximum
//   underflow    one-cycle pulse when a decrement passes zero
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter     MODE         = "HEX",
    parameter int NUM_SEGMENTS = 4,
    parameter     LIMIT        = "WRAP",
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_up,
    input  logic                         btn_down,
    output logic [NUM_SEGMENTS-1:0][3:0] encoded,
    output logic [NUM_SEGMENTS-1:0]      digit_point,
    output logic [NUM_SEGMENTS-1:0]      digit_blank,
    output logic                         overflow,
    output logic                         underflow
);

    localparam bit IS_DEC = (MODE == "DEC");
    localparam bit IS_SAT = (LIMIT == "SAT");

    localparam logic [3:0] DIGIT_MAX = IS_DEC ? 4'd9 : 4'd15;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // The timer only ever holds DELAY-1 or RATE-1, so it is sized to the
    // larger of the two.
    localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW        = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX);

    localparam logic [TW-1:0] DELAY_LOAD = (REPEAT_DELAY > 0) ? TW'(REPEAT_DELAY - 1) : '0;
    localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

    localparam logic [1:0] AFTER_PRESS = (REPEAT_DELAY > 0) ? ST_DELAY : ST_IDLE;

    logic [NUM_SEGMENTS-1:0][3:0] count_q, count_d;
    logic [1:0]                   state_q, state_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic                         dir_up_q, dir_up_d;
    logic                         prev_up_q, prev_up_d;
    logic                         prev_down_q, prev_down_d;
    logic                         overflow_q, overflow_d;
    logic                         underflow_q, underflow_d;

    logic [NUM_SEGMENTS-1:0][3:0] inc_value;
    logic [NUM_SEGMENTS-1:0][3:0] dec_value;
    logic                         inc_carry;
    logic                         dec_borrow;

    logic up_press;
    logic down_press;
    logic active_held;
    logic other_held;
    logic do_step;
    logic step_up;
    logic zero_run;

    // Digit-wise ripple increment and decrement. A carry out of the top
    // digit (all digits at DIGIT_MAX) means the count was at MAX; a borrow
    // out means it was at zero. In both cases the rippled value is already
    // the wrapped result, so WRAP needs no special handling.
    always_comb begin
        inc_value  = count_q;
        dec_value  = count_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (inc_carry) begin
                if (count_q[i] >= DIGIT_MAX) begin
                    inc_value[i] = 4'd0;
                end else begin
                    inc_value[i] = count_q[i] + 4'd1;
                    inc_carry    = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count_q[i] == 4'd0) begin
                    dec_value[i] = DIGIT_MAX;
                end else begin
                    dec_value[i] = count_q[i] - 4'd1;
                    dec_borrow   = 1'b0;
                end
            end
        end
    end

    // Button edge detection and the IDLE/DELAY/REPEAT sequencer. The timer
    // counts down to zero; a step fires on the edge where it reads zero, so
    // loading N-1 places the next step exactly N cycles later. A press while
    // the other button is held, or both buttons high, never steps.
    always_comb begin
        up_press    = btn_up & ~prev_up_q;
        down_press  = btn_down & ~prev_down_q;
        prev_up_d   = btn_up;
        prev_down_d = btn_down;
        active_held = dir_up_q ? btn_up : btn_down;
        other_held  = dir_up_q ? btn_down : btn_up;
        do_step     = 1'b0;
        step_up     = 1'b0;
        state_d     = state_q;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_up && btn_down) begin
                    timer_d = '0;
                end else if (up_press) begin
                    do_step  = 1'b1;
                    step_up  = 1'b1;
                    dir_up_d = 1'b1;
                    timer_d  = DELAY_LOAD;
                    state_d  = AFTER_PRESS;
                end else if (down_press) begin
                    do_step  = 1'b1;
                    step_up  = 1'b0;
                    dir_up_d = 1'b0;
                    timer_d  = DELAY_LOAD;
                    state_d  = AFTER_PRESS;
                end
            end

            ST_DELAY, ST_REPEAT: begin
                if (!active_held || other_held) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    do_step = 1'b1;
                    step_up = dir_up_q;
                    timer_d = RATE_LOAD;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Apply a step to the count. Under SAT a blocked step leaves the count
    // alone but still reports the overflow/underflow, so held buttons keep
    // pulsing the flag at the repeat rate. Only one direction steps per
    // edge, so the two flags are mutually exclusive by construction.
    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (do_step) begin
            if (step_up) begin
                overflow_d = inc_carry;
                if (!(inc_carry && IS_SAT)) begin
                    count_d = inc_value;
                end
            end else begin
                underflow_d = dec_borrow;
                if (!(dec_borrow && IS_SAT)) begin
                    count_d = dec_value;
                end
            end
        end
    end

    // Leading-zero blanking: scan from the most significant digit down and
    // keep flagging digits while every digit above and including them is
    // zero. Digit 0 is never blanked so zero still shows as "0".
    always_comb begin
        zero_run    = 1'b1;
        digit_blank = '0;
        for (int i = NUM_SEGMENTS - 1; i >= 1; i--) begin
            zero_run       = zero_run & (count_q[i] == 4'd0);
            digit_blank[i] = zero_run;
        end
    end

    // Decimal point on digit 0 lights (active low) while auto-repeating.
    always_comb begin
        digit_point    = '1;
        digit_point[0] = (state_q != ST_REPEAT);
    end

    // State registers. The previous-sample registers reset to 1 so a button
    // already held when reset releases cannot look like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            dir_up_q    <= 1'b1;
            prev_up_q   <= 1'b1;
            prev_down_q <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            dir_up_q    <= dir_up_d;
            prev_up_q   <= prev_up_d;
            prev_down_q <= prev_down_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign encoded   = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Drives three differently configured counters from one shared pair of
// buttons and compares every output, every cycle, against a reference model
// that tracks the count as a plain integer and the button hold time as a
// cycle count since the press.
//   u0: DEC, 2 digits, WRAP, delay 8, rate 4
//   u1: HEX, 2 digits, SAT,  delay 3, rate 2
//   u2: DEC, 3 digits, SAT,  no auto-repeat
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_down;

    logic [1:0][3:0] enc0;
    logic [1:0]      dp0, db0;
    logic            ov0, un0;
    logic [1:0][3:0] enc1;
    logic [1:0]      dp1, db1;
    logic            ov1, un1;
    logic [2:0][3:0] enc2;
    logic [2:0]      dp2, db2;
    logic            ov2, un2;

    always #5 clk = ~clk;

    bcd_updown_counter #(
        .MODE("DEC"), .NUM_SEGMENTS(2), .LIMIT("WRAP"), .REPEAT_DELAY(8), .REPEAT_RATE(4)
    ) u0 (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .encoded(enc0), .digit_point(dp0), .digit_blank(db0),
        .overflow(ov0), .underflow(un0)
    );

    bcd_updown_counter #(
        .MODE("HEX"), .NUM_SEGMENTS(2), .LIMIT("SAT"), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) u1 (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .encoded(enc1), .digit_point(dp1), .digit_blank(db1),
        .overflow(ov1), .underflow(un1)
    );

    bcd_updown_counter #(
        .MODE("DEC"), .NUM_SEGMENTS(3), .LIMIT("SAT"), .REPEAT_DELAY(0), .REPEAT_RATE(1)
    ) u2 (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .encoded(enc2), .digit_point(dp2), .digit_blank(db2),
        .overflow(ov2), .underflow(un2)
    );

    // Per-instance configuration as seen by the model
    int cfgRadix  [3] = '{10, 16, 10};
    int cfgDigits [3] = '{2, 2, 3};
    bit cfgSat    [3] = '{1'b0, 1'b1, 1'b1};
    int cfgDelay  [3] = '{8, 3, 0};
    int cfgRate   [3] = '{4, 2, 1};

    // Model state: count as an integer, active direction (+1/-1/0) and the
    // number of edges the active button has been held since its press.
    int mValue  [3];
    int mActive [3];
    int mHeld   [3];
    bit mOv     [3];
    bit mUn     [3];
    bit mPrevUp;
    bit mPrevDown;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int powerOf(int radix, int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * radix;
        return r;
    endfunction

    function automatic int maxOf(int k);
        return powerOf(cfgRadix[k], cfgDigits[k]) - 1;
    endfunction

    function automatic logic [31:0] expectEncoded(int k);
        logic [31:0] r = '0;
        int v = mValue[k];
        for (int i = 0; i < cfgDigits[k]; i++) begin
            r = r | (32'(v % cfgRadix[k]) << (4 * i));
            v = v / cfgRadix[k];
        end
        return r;
    endfunction

    // A digit is a leading zero when the whole value fits below its weight.
    function automatic logic [31:0] expectBlank(int k);
        logic [31:0] r = '0;
        for (int i = 1; i < cfgDigits[k]; i++) begin
            if (mValue[k] < powerOf(cfgRadix[k], i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] expectPoint(int k);
        logic [31:0] r = '0;
        for (int i = 0; i < cfgDigits[k]; i++) r[i] = 1'b1;
        if (mActive[k] != 0 && cfgDelay[k] > 0 && mHeld[k] >= cfgDelay[k]) r[0] = 1'b0;
        return r;
    endfunction

    task automatic modelStep(input int k, input bit up);
        if (up) begin
            if (mValue[k] == maxOf(k)) begin
                mOv[k]    = 1'b1;
                mValue[k] = cfgSat[k] ? maxOf(k) : 0;
            end else begin
                mValue[k]++;
            end
        end else begin
            if (mValue[k] == 0) begin
                mUn[k]    = 1'b1;
                mValue[k] = cfgSat[k] ? 0 : maxOf(k);
            end else begin
                mValue[k]--;
            end
        end
    endtask

    task automatic modelEdge(input int k, input bit up, input bit down, input bit rst);
        bit activeHeld;
        bit otherHeld;
        mOv[k] = 1'b0;
        mUn[k] = 1'b0;
        if (rst) begin
            mValue[k]  = 0;
            mActive[k] = 0;
            mHeld[k]   = 0;
        end else if (mActive[k] != 0) begin
            activeHeld = (mActive[k] > 0) ? up : down;
            otherHeld  = (mActive[k] > 0) ? down : up;
            if (!activeHeld || otherHeld) begin
                mActive[k] = 0;
                mHeld[k]   = 0;
            end else begin
                mHeld[k]++;
                if (mHeld[k] >= cfgDelay[k] && ((mHeld[k] - cfgDelay[k]) % cfgRate[k]) == 0)
                    modelStep(k, mActive[k] > 0);
            end
        end else if (!(up && down)) begin
            if (up && !mPrevUp) begin
                modelStep(k, 1'b1);
                if (cfgDelay[k] > 0) begin
                    mActive[k] = 1;
                    mHeld[k]   = 0;
                end
            end else if (down && !mPrevDown) begin
                modelStep(k, 1'b0);
                if (cfgDelay[k] > 0) begin
                    mActive[k] = -1;
                    mHeld[k]   = 0;
                end
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("u0.encoded", 32'(enc0), expectEncoded(0));
        checkOutput("u0.blank", 32'(db0), expectBlank(0));
        checkOutput("u0.point", 32'(dp0), expectPoint(0));
        checkOutput("u0.overflow", 32'(ov0), 32'(mOv[0]));
        checkOutput("u0.underflow", 32'(un0), 32'(mUn[0]));
        checkOutput("u1.encoded", 32'(enc1), expectEncoded(1));
        checkOutput("u1.blank", 32'(db1), expectBlank(1));
        checkOutput("u1.point", 32'(dp1), expectPoint(1));
        checkOutput("u1.overflow", 32'(ov1), 32'(mOv[1]));
        checkOutput("u1.underflow", 32'(un1), 32'(mUn[1]));
        checkOutput("u2.encoded", 32'(enc2), expectEncoded(2));
        checkOutput("u2.blank", 32'(db2), expectBlank(2));
        checkOutput("u2.point", 32'(dp2), expectPoint(2));
        checkOutput("u2.overflow", 32'(ov2), 32'(mOv[2]));
        checkOutput("u2.underflow", 32'(un2), 32'(mUn[2]));
    endtask

    // Holds the given inputs for a number of clock edges, advancing the
    // model on each edge and comparing every output just after it.
    task automatic applyStimulus(input bit up, input bit down, input bit rst, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            btn_up   = up;
            btn_down = down;
            reset    = rst;
            @(posedge clk);
            for (int k = 0; k < 3; k++) modelEdge(k, up, down, rst);
            mPrevUp   = rst ? 1'b1 : up;
            mPrevDown = rst ? 1'b1 : down;
            #1;
            compareAll();
        end
    endtask

    initial begin
        int pattern;
        int len;
        reset    = 1'b1;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        mPrevUp   = 1'b1;
        mPrevDown = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mValue[k]  = 0;
            mActive[k] = 0;
            mHeld[k]   = 0;
            mOv[k]     = 1'b0;
            mUn[k]     = 1'b0;
        end

        // Reset with both buttons held, then keep holding: no step allowed
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        checkOutput("reset.u0.encoded", 32'(enc0), 32'h00);
        checkOutput("reset.u0.blank", 32'(db0), 32'h2);
        checkOutput("reset.u0.point", 32'(dp0), 32'h3);
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);

        // Decrement at zero, then increment back through MAX
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("wrap.u0.under", 32'(enc0), 32'h99);
        checkOutput("sat.u1.under", 32'(enc1), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("wrap.u0.over", 32'(enc0), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);

        // Five taps, then a 20-cycle hold for the delay/repeat timing
        for (int t = 0; t < 5; t++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);

        // Both rise together, then a down press while up is still held
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);

        // Long holds through both range ends, with a reset mid-repeat
        applyStimulus(1'b1, 1'b0, 1'b0, 500);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 6);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 40);
        applyStimulus(1'b0, 1'b1, 1'b0, 500);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);

        // Tap up enough times to saturate the three-digit counter
        for (int t = 0; t < 1010; t++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(1, 2));
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
        end

        // Random button patterns with occasional resets
        for (int s = 0; s < 400; s++) begin
            pattern = $urandom_range(0, 3);
            len     = $urandom_range(1, 30);
            if ($urandom_range(0, 49) == 0) applyStimulus(pattern[0], pattern[1], 1'b1, 1);
            applyStimulus(pattern[0], pattern[1], 1'b0, len);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
